// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, ALU/pc_sel/state encodings for the decode stage
package decode_pkg;

  // RV32I major opcodes (instr[6:0], including the 2'b11 length bits)
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_IMM  = 2'b01,
    PC_ALU  = 2'b10,
    PC_HOLD = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  // funct3 selects the operation; alt picks SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction and format classification
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm,
  output imm_fmt_e    o_fmt
);

  // classify the instruction format from its opcode; unknown opcodes read as R (no immediate)
  always_comb begin
    o_fmt = FMT_R;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: o_fmt = FMT_I;
      OPC_STORE:                      o_fmt = FMT_S;
      OPC_BRANCH:                     o_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             o_fmt = FMT_U;
      OPC_JAL:                        o_fmt = FMT_J;
      default:                        o_fmt = FMT_R;
    endcase
  end

  // assemble the immediate, always sign-extending from instr[31]
  always_comb begin
    o_imm = 32'd0;
    case (o_fmt)
      FMT_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      FMT_U: o_imm = {i_instr[31:12], 12'd0};
      FMT_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID register, RV32I decode and fetch redirect control
module decode_stage
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_valid,
  input  logic [DATA_WIDTH-1:0] i_if_instr,
  input  logic [ADDR_WIDTH-1:0] i_if_pc,
  output logic                  o_id_ready,
  output logic [1:0]            o_pc_sel,
  output logic [ADDR_WIDTH-1:0] o_imm_addr,
  input  logic                  i_ex_ready,
  input  logic                  i_ex_flush,
  output logic                  o_id_valid,
  output logic [ADDR_WIDTH-1:0] o_id_pc,
  output logic [4:0]            o_id_rs1,
  output logic [4:0]            o_id_rs2,
  output logic [4:0]            o_id_rd,
  output logic [31:0]           o_id_imm,
  output logic [3:0]            o_id_alu_op,
  output logic                  o_id_rf_we,
  output logic                  o_id_mem_rd,
  output logic                  o_id_mem_wr,
  output logic                  o_id_branch,
  output logic                  o_id_jal,
  output logic                  o_id_jalr,
  output logic                  o_id_illegal
);

  state_e                r_state;
  state_e                w_state_nxt;
  pc_sel_e               w_pc_sel;
  logic                  w_id_ready;

  logic                  r_id_valid;
  logic [ADDR_WIDTH-1:0] r_id_pc;
  logic [4:0]            r_id_rs1;
  logic [4:0]            r_id_rs2;
  logic [4:0]            r_id_rd;
  logic [31:0]           r_id_imm;
  alu_op_e               r_id_alu_op;
  logic                  r_id_rf_we;
  logic                  r_id_mem_rd;
  logic                  r_id_mem_wr;
  logic                  r_id_branch;
  logic                  r_id_jal;
  logic                  r_id_jalr;
  logic                  r_id_illegal;
  logic [ADDR_WIDTH-1:0] r_imm_addr;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [4:0]            w_rd;
  logic [31:0]           w_imm;
  imm_fmt_e              w_fmt;
  logic                  w_known_opc;
  logic                  w_is_jal;
  logic                  w_illegal;
  alu_op_e               w_alu_op;
  logic                  w_writes_rd;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_jal_taken;
  logic [ADDR_WIDTH-1:0] w_jal_target;

  assign w_opcode = i_if_instr[6:0];
  assign w_funct3 = i_if_instr[14:12];
  assign w_rd     = i_if_instr[11:7];

  imm_gen u_imm_gen (
    .i_instr (i_if_instr),
    .o_imm   (w_imm),
    .o_fmt   (w_fmt)
  );

  // A misaligned JAL target is flagged illegal but still redirects fetch
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_illegal   = !w_known_opc || (w_is_jal && w_imm[1]);

  assign w_stall     = r_id_valid && !i_ex_ready;
  assign w_accept    = !i_rst && i_if_valid && (r_state == ST_RUN) && !w_stall && !i_ex_flush;
  assign w_jal_taken = w_accept && w_is_jal;
  assign w_jal_target = i_if_pc + w_imm[ADDR_WIDTH+1:2];

  // opcode legality, ALU op and rd-write class for the incoming word
  always_comb begin
    w_known_opc = 1'b1;
    w_alu_op    = ALU_ADD;
    w_writes_rd = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_alu_op    = alu_from_funct3(w_funct3, i_if_instr[30]);
        w_writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except on the right-shift encodings
        w_alu_op    = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && i_if_instr[30]);
        w_writes_rd = 1'b1;
      end
      OPC_LUI: begin
        w_alu_op    = ALU_PASSB;
        w_writes_rd = 1'b1;
      end
      OPC_LOAD, OPC_JAL, OPC_JALR, OPC_AUIPC: w_writes_rd = 1'b1;
      OPC_STORE:  w_alu_op = ALU_ADD;
      OPC_BRANCH: w_alu_op = ALU_SUB;
      default:    w_known_opc = 1'b0;
    endcase
  end

  // next state, fetch select and ready; flush outranks JAL outranks stall
  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PC_SEQ;
    w_id_ready  = 1'b0;
    if (!i_rst) begin
      w_id_ready = (r_state == ST_SQUASH) || i_ex_flush || !w_stall;
      if (i_ex_flush) begin
        w_pc_sel    = PC_ALU;
        w_state_nxt = ST_SQUASH;
      end else if (w_jal_taken) begin
        w_pc_sel    = PC_IMM;
        w_state_nxt = ST_SQUASH;
      end else begin
        if (w_stall) begin
          w_pc_sel = PC_HOLD;
        end
        w_state_nxt = ST_RUN;
      end
    end
  end

  // state register; SQUASH lasts one cycle unless re-entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IF/ID pipeline register: load on accept, drop on flush or drain, hold on stall
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_rs1     <= 5'd0;
      r_id_rs2     <= 5'd0;
      r_id_rd      <= 5'd0;
      r_id_imm     <= 32'd0;
      r_id_alu_op  <= ALU_ADD;
      r_id_rf_we   <= 1'b0;
      r_id_mem_rd  <= 1'b0;
      r_id_mem_wr  <= 1'b0;
      r_id_branch  <= 1'b0;
      r_id_jal     <= 1'b0;
      r_id_jalr    <= 1'b0;
      r_id_illegal <= 1'b0;
    end else if (w_accept) begin
      r_id_valid   <= 1'b1;
      r_id_pc      <= i_if_pc;
      r_id_rs1     <= i_if_instr[19:15];
      r_id_rs2     <= i_if_instr[24:20];
      r_id_rd      <= w_rd;
      r_id_imm     <= w_imm;
      r_id_alu_op  <= w_illegal ? ALU_ADD : w_alu_op;
      r_id_rf_we   <= w_writes_rd && (w_rd != 5'd0) && !w_illegal;
      r_id_mem_rd  <= (w_opcode == OPC_LOAD) && !w_illegal;
      r_id_mem_wr  <= (w_opcode == OPC_STORE) && !w_illegal;
      r_id_branch  <= (w_opcode == OPC_BRANCH) && !w_illegal;
      r_id_jal     <= w_is_jal && !w_illegal;
      r_id_jalr    <= (w_opcode == OPC_JALR) && !w_illegal;
      r_id_illegal <= w_illegal;
    end else if (i_ex_flush || (r_id_valid && i_ex_ready)) begin
      r_id_valid   <= 1'b0;
    end
  end

  // remember the last JAL target so imm_addr stays stable between redirects
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_imm_addr <= '0;
    end else if (w_jal_taken) begin
      r_imm_addr <= w_jal_target;
    end
  end

  assign o_id_ready   = w_id_ready;
  assign o_pc_sel     = w_pc_sel;
  assign o_imm_addr   = w_jal_taken ? w_jal_target : r_imm_addr;
  assign o_id_valid   = r_id_valid;
  assign o_id_pc      = r_id_pc;
  assign o_id_rs1     = r_id_rs1;
  assign o_id_rs2     = r_id_rs2;
  assign o_id_rd      = r_id_rd;
  assign o_id_imm     = r_id_imm;
  assign o_id_alu_op  = r_id_alu_op;
  assign o_id_rf_we   = r_id_rf_we;
  assign o_id_mem_rd  = r_id_mem_rd;
  assign o_id_mem_wr  = r_id_mem_wr;
  assign o_id_branch  = r_id_branch;
  assign o_id_jal     = r_id_jal;
  assign o_id_jalr    = r_id_jalr;
  assign o_id_illegal = r_id_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [10:0] if_pc;
  logic        id_ready;
  logic [1:0]  pc_sel;
  logic [10:0] imm_addr;
  logic        ex_ready;
  logic        ex_flush;
  logic        id_valid;
  logic [10:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_rf_we, id_mem_rd, id_mem_wr;
  logic        id_branch, id_jal, id_jalr, id_illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_valid   (if_valid),
    .i_if_instr   (if_instr),
    .i_if_pc      (if_pc),
    .o_id_ready   (id_ready),
    .o_pc_sel     (pc_sel),
    .o_imm_addr   (imm_addr),
    .i_ex_ready   (ex_ready),
    .i_ex_flush   (ex_flush),
    .o_id_valid   (id_valid),
    .o_id_pc      (id_pc),
    .o_id_rs1     (id_rs1),
    .o_id_rs2     (id_rs2),
    .o_id_rd      (id_rd),
    .o_id_imm     (id_imm),
    .o_id_alu_op  (id_alu_op),
    .o_id_rf_we   (id_rf_we),
    .o_id_mem_rd  (id_mem_rd),
    .o_id_mem_wr  (id_mem_wr),
    .o_id_branch  (id_branch),
    .o_id_jal     (id_jal),
    .o_id_jalr    (id_jalr),
    .o_id_illegal (id_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] instr, input logic [10:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 11'h000;
    ex_ready = 1'b1; ex_flush = 1'b0;

    tick();
    chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
    chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    rst = 1'b0; if_valid = 1'b0;
    #1;
    chk("post_rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("post_rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    chk("post_rst_id_pc", {21'd0, id_pc}, 32'd0);
    chk("post_rst_id_rd", {27'd0, id_rd}, 32'd0);
    chk("post_rst_id_imm", id_imm, 32'd0);
    chk("post_rst_rf_we", {31'd0, id_rf_we}, 32'd0);
    chk("post_rst_imm_addr", {21'd0, imm_addr}, 32'd0);

    // ADDI x5,x0,-1
    beat(32'hFFF00293, 11'h004);
    chk("addi_id_ready", {31'd0, id_ready}, 32'd1);
    chk("addi_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_pc", {21'd0, id_pc}, 32'h004);
    chk("addi_rd", {27'd0, id_rd}, 32'd5);
    chk("addi_rs1", {27'd0, id_rs1}, 32'd0);
    chk("addi_imm", id_imm, 32'hFFFFFFFF);
    chk("addi_alu", {28'd0, id_alu_op}, 32'd0);
    chk("addi_rf_we", {31'd0, id_rf_we}, 32'd1);

    // JAL x1,+16 at 0x010 redirects to 0x014
    beat(32'h010000EF, 11'h010);
    chk("jal_pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("jal_imm_addr", {21'd0, imm_addr}, 32'h014);
    tick();
    chk("jal_valid", {31'd0, id_valid}, 32'd1);
    chk("jal_id_pc", {21'd0, id_pc}, 32'h010);
    chk("jal_rd", {27'd0, id_rd}, 32'd1);
    chk("jal_flag", {31'd0, id_jal}, 32'd1);
    chk("jal_rf_we", {31'd0, id_rf_we}, 32'd1);
    chk("jal_imm", id_imm, 32'd16);
    beat(32'h00100093, 11'h011);
    chk("squash_id_ready", {31'd0, id_ready}, 32'd1);
    chk("squash_pc_sel", {30'd0, pc_sel}, 32'd0);
    chk("squash_imm_addr_held", {21'd0, imm_addr}, 32'h014);
    tick();
    chk("squash_dropped", {31'd0, id_valid}, 32'd0);

    // SW x5,4(x3) at the JAL target
    beat(32'h0051A223, 11'h014);
    tick();
    chk("sw_valid", {31'd0, id_valid}, 32'd1);
    chk("sw_pc", {21'd0, id_pc}, 32'h014);
    chk("sw_mem_wr", {31'd0, id_mem_wr}, 32'd1);
    chk("sw_imm", id_imm, 32'd4);
    chk("sw_rs1", {27'd0, id_rs1}, 32'd3);
    chk("sw_rs2", {27'd0, id_rs2}, 32'd5);
    chk("sw_rf_we", {31'd0, id_rf_we}, 32'd0);

    // backpressure for three cycles with an all-zero word waiting
    ex_ready = 1'b0;
    beat(32'h00000000, 11'h015);
    for (int i = 0; i < 3; i++) begin
      chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
      chk("stall_pc_sel", {30'd0, pc_sel}, 32'd3);
      tick();
      chk("stall_id_pc", {21'd0, id_pc}, 32'h014);
      chk("stall_mem_wr", {31'd0, id_mem_wr}, 32'd1);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
      #1;
    end
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", {31'd0, id_ready}, 32'd1);
    chk("release_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    chk("zero_valid", {31'd0, id_valid}, 32'd1);
    chk("zero_pc", {21'd0, id_pc}, 32'h015);
    chk("zero_illegal", {31'd0, id_illegal}, 32'd1);
    chk("zero_rf_we", {31'd0, id_rf_we}, 32'd0);
    chk("zero_mem_wr", {31'd0, id_mem_wr}, 32'd0);

    // execute flush: redirect, drop one beat, accept the next
    ex_flush = 1'b1;
    beat(32'hFFF00293, 11'h016);
    chk("flush_pc_sel", {30'd0, pc_sel}, 32'd2);
    tick();
    ex_flush = 1'b0;
    beat(32'h00100093, 11'h020);
    chk("flush_valid_cleared", {31'd0, id_valid}, 32'd0);
    chk("flush_squash_ready", {31'd0, id_ready}, 32'd1);
    chk("flush_squash_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    chk("flush_beat_dropped", {31'd0, id_valid}, 32'd0);

    // LUI x7,0x12345
    beat(32'h123453B7, 11'h021);
    tick();
    chk("lui_valid", {31'd0, id_valid}, 32'd1);
    chk("lui_pc", {21'd0, id_pc}, 32'h021);
    chk("lui_imm", id_imm, 32'h12345000);
    chk("lui_alu", {28'd0, id_alu_op}, 32'd10);
    chk("lui_rd", {27'd0, id_rd}, 32'd7);

    // flush coincides with a JAL, then flush again during SQUASH
    ex_flush = 1'b1;
    beat(32'h010000EF, 11'h030);
    chk("flush_jal_pc_sel", {30'd0, pc_sel}, 32'd2);
    tick();
    beat(32'h00100093, 11'h031);
    chk("reflush_pc_sel", {30'd0, pc_sel}, 32'd2);
    chk("reflush_valid", {31'd0, id_valid}, 32'd0);
    tick();
    ex_flush = 1'b0;
    beat(32'h00100093, 11'h032);
    chk("reflush_squash_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    chk("reflush_dropped", {31'd0, id_valid}, 32'd0);

    // SUB x3,x1,x2
    beat(32'h402081B3, 11'h040);
    tick();
    chk("sub_alu", {28'd0, id_alu_op}, 32'd1);
    chk("sub_imm", id_imm, 32'd0);
    chk("sub_regs", {17'd0, id_rd, id_rs1, id_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});

    // SRAI x1,x1,3: funct7[5] selects SRA on shifts
    beat(32'h4030D093, 11'h041);
    tick();
    chk("srai_alu", {28'd0, id_alu_op}, 32'd7);
    chk("srai_imm", id_imm, 32'h00000403);

    // ADDI x1,x0,0x400: instr[30] set but ADDI stays ADD
    beat(32'h40000093, 11'h042);
    tick();
    chk("addi_b30_alu", {28'd0, id_alu_op}, 32'd0);
    chk("addi_b30_imm", id_imm, 32'h00000400);

    // ADDI x0,x0,0: rd==0 never writes
    beat(32'h00000013, 11'h043);
    tick();
    chk("nop_rf_we", {31'd0, id_rf_we}, 32'd0);
    chk("nop_illegal", {31'd0, id_illegal}, 32'd0);

    // low bits 01 is illegal
    beat(32'hFFF00291, 11'h044);
    tick();
    chk("lowbits_illegal", {31'd0, id_illegal}, 32'd1);
    chk("lowbits_rf_we", {31'd0, id_rf_we}, 32'd0);

    // JAL x1,-16 at 0x002 wraps to 0x7FE
    beat(32'hFF1FF0EF, 11'h002);
    chk("jal_wrap_pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("jal_wrap_imm_addr", {21'd0, imm_addr}, 32'h7FE);
    tick();
    chk("jal_neg_imm", id_imm, 32'hFFFFFFF0);
    chk("jal_neg_flag", {31'd0, id_jal}, 32'd1);
    if_valid = 1'b0;
    tick();

    // JAL +2: misaligned target still redirects but is flagged illegal
    beat(32'h002000EF, 11'h050);
    chk("jal_mis_pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("jal_mis_imm_addr", {21'd0, imm_addr}, 32'h050);
    tick();
    chk("jal_mis_illegal", {31'd0, id_illegal}, 32'd1);
    chk("jal_mis_rf_we", {31'd0, id_rf_we}, 32'd0);
    if_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
